// File: rtl/rock_core_pkg.sv
// Shared core definitions: fetch FSM states, PC step and the default boot address.
package rock_core_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_INC = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;

  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request channel: valid/ready handshake carrying the fetch address.
interface fetch_pc_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;

  modport master (output req_valid, output req_addr, input req_ready);
  modport slave  (input req_valid, input req_addr, output req_ready);
endinterface

// File: rtl/Register_R.sv
// Generic enabled register with synchronous active-high reset to INIT.
module Register_R #(
  parameter int          N    = 32,
  parameter logic [N-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // state register: reset to INIT, load on enable
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= INIT;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pc_redirect_latch.sv
// Holds the most recent redirect target seen while a fetch request is outstanding.
module pc_redirect_latch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [XLEN-1:0] target,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_target
);

  logic            valid_r;
  logic [XLEN-1:0] target_r;

  // pending target capture; clear dominates because the consumer applies it that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r  <= 1'b0;
      target_r <= '0;
    end else if (clr) begin
      valid_r  <= 1'b0;
      target_r <= '0;
    end else if (load) begin
      valid_r  <= 1'b1;
      target_r <= target;
    end else begin
      valid_r  <= valid_r;
      target_r <= target_r;
    end
  end

  assign pend_valid  = valid_r;
  assign pend_target = target_r;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC sequencer: boot, issue, backpressure wait and debug halt around one PC register.
// Optional macro PC_MISALIGN_CHECK_EN drops non-word-aligned redirects and flags misalign_err.
module fetch_pc_unit
  import rock_core_pkg::*;
#(
  parameter int            XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt_req,
  input  logic            resume,
  fetch_pc_unit_if.master imem,
  output logic [XLEN-1:0] pc,
  output logic            halted
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  fetch_state_e    state_r;
  logic            halt_pend_r;
  logic            halted_r;
  logic            redir_ok_s;
  logic            req_valid_s;
  logic            pc_en_s;
  logic            latch_clr_s;
  logic            latch_load_s;
  logic            pend_valid_s;
  logic [XLEN-1:0] pc_q_s;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] pc_inc_s;
  logic [XLEN-1:0] pend_target_s;

`ifdef PC_MISALIGN_CHECK_EN
  logic misalign_r;

  assign redir_ok_s = redirect_valid && !addr_misaligned(redirect_target[1:0]);

  // one-cycle flag for each rejected redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= redirect_valid && addr_misaligned(redirect_target[1:0]);
    end
  end

  assign misalign_err = misalign_r;
`else
  assign redir_ok_s = redirect_valid;
`endif

  // natural XLEN-bit add gives the required wrap to zero
  assign pc_inc_s = pc_q_s + XLEN'(PC_INC);

  // request valid: RUN issues unless held off, WAIT never withdraws
  always_comb begin
    req_valid_s = 1'b0;
    case (state_r)
      ST_RUN:  req_valid_s = !stall && !halt_req;
      ST_WAIT: req_valid_s = 1'b1;
      default: req_valid_s = 1'b0;
    endcase
  end

  // PC and pending-latch control: at most one PC update per cycle
  always_comb begin
    pc_en_s      = 1'b0;
    pc_next_s    = pc_q_s;
    latch_clr_s  = 1'b0;
    latch_load_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (req_valid_s) begin
          if (imem.req_ready) begin
            pc_en_s   = 1'b1;
            pc_next_s = redir_ok_s ? redirect_target : pc_inc_s;
          end else begin
            latch_load_s = redir_ok_s;
          end
        end else begin
          pc_en_s   = redir_ok_s;
          pc_next_s = redirect_target;
        end
      end
      ST_WAIT: begin
        if (imem.req_ready) begin
          pc_en_s     = 1'b1;
          latch_clr_s = 1'b1;
          if (redir_ok_s) begin
            pc_next_s = redirect_target;
          end else if (pend_valid_s) begin
            pc_next_s = pend_target_s;
          end else begin
            pc_next_s = pc_inc_s;
          end
        end else begin
          latch_load_s = redir_ok_s;
        end
      end
      ST_HALTED: begin
        pc_en_s   = redir_ok_s;
        pc_next_s = redirect_target;
      end
      default: begin
        pc_en_s   = 1'b0;
        pc_next_s = pc_q_s;
      end
    endcase
  end

  Register_R #(
    .N    (XLEN),
    .INIT (RESET_VECTOR)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en_s),
    .d   (pc_next_s),
    .q   (pc_q_s)
  );

  pc_redirect_latch #(
    .XLEN (XLEN)
  ) u_redirect_latch (
    .clk         (clk),
    .rst         (rst),
    .clr         (latch_clr_s),
    .load        (latch_load_s),
    .target      (redirect_target),
    .pend_valid  (pend_valid_s),
    .pend_target (pend_target_s)
  );

  // fetch FSM with registered halted flag and pending-halt bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_BOOT;
      halt_pend_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r     <= ST_RUN;
          halt_pend_r <= 1'b0;
          halted_r    <= 1'b0;
        end
        ST_RUN: begin
          if (halt_req) begin
            state_r  <= ST_HALTED;
            halted_r <= 1'b1;
          end else if (req_valid_s && !imem.req_ready) begin
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_WAIT: begin
          if (imem.req_ready) begin
            halt_pend_r <= 1'b0;
            if (halt_pend_r || halt_req) begin
              state_r  <= ST_HALTED;
              halted_r <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end else if (halt_req) begin
            halt_pend_r <= 1'b1;
          end else begin
            halt_pend_r <= halt_pend_r;
          end
        end
        ST_HALTED: begin
          if (resume && !halt_req) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
          end else begin
            state_r <= ST_HALTED;
          end
        end
        default: begin
          state_r     <= ST_BOOT;
          halt_pend_r <= 1'b0;
          halted_r    <= 1'b0;
        end
      endcase
    end
  end

  assign imem.req_valid = req_valid_s;
  assign imem.req_addr  = pc_q_s;
  assign pc             = pc_q_s;
  assign halted         = halted_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed vector bench for fetch_pc_unit; builds with or without PC_MISALIGN_CHECK_EN.
module tb_fetch_pc_unit;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] rt;
    logic        halt;
    logic        resume;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_addr;
    logic        e_halted;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic        halted;
`ifdef PC_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_vec;
  int n_err;
  vec_t vecs[$];

  fetch_pc_unit_if #(.XLEN(32)) imem_if ();

  fetch_pc_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .resume          (resume),
    .imem            (imem_if),
    .pc              (pc),
    .halted          (halted)
`ifdef PC_MISALIGN_CHECK_EN
    ,
    .misalign_err    (misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic v, input logic [31:0] t,
                              input logic h, input logic rs, input logic rdy,
                              input logic ev, input logic [31:0] ea, input logic eh);
    vec_t x;
    x.rst = r; x.stall = s; x.rv = v; x.rt = t; x.halt = h; x.resume = rs; x.ready = rdy;
    x.e_valid = ev; x.e_addr = ea; x.e_halted = eh;
    return x;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic v, input logic [31:0] t,
                       input logic h, input logic rs, input logic rdy);
    rst = r; stall = s; redirect_valid = v; redirect_target = t;
    halt_req = h; resume = rs; imem_if.req_ready = rdy;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    //             rst   stl   rv    target        hlt   res   rdy   valid addr          halted
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0004, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0008, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_000C, 1'b0));
    // backpressure at 0x80000010 with two redirects, latest wins
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0010, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h100,      1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0010, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'h200,      1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0010, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0010, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h200,       1'b0));
    // stall with redirect loads pc directly
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'h400,      1'b0, 1'b0, 1'b1, 1'b0, 32'h204,       1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h400,       1'b0));
    // halt while waiting, redirect in HALTED, resume blocked by halt_req, then resume
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h404,       1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h404,       1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h404,       1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h408,       1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h500,      1'b0, 1'b0, 1'b1, 1'b0, 32'h408,       1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h500,       1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h500,       1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h500,       1'b0));
    // wrap: accepted redirect to all-ones-minus-3, then +4 gives zero
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b1, 32'h504,      1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         1'b0));
    // halt_req in RUN
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h4,         1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h4,         1'b1));
    // WAIT accept: same-cycle redirect beats pending
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h4,         1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h600,      1'b0, 1'b0, 1'b0, 1'b1, 32'h4,         1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h700,      1'b0, 1'b0, 1'b1, 1'b1, 32'h4,         1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h700,       1'b0));
    // RUN refused request: redirect goes to pending, not pc
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h800,      1'b0, 1'b0, 1'b0, 1'b1, 32'h704,       1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h704,       1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h704,       1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h800,       1'b0));
    // reset during WAIT abandons the request
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h804,       1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h900,      1'b0, 1'b0, 1'b0, 1'b1, 32'h804,       1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rt, vecs[i].halt, vecs[i].resume, vecs[i].ready);
      #1;
      check($sformatf("vec%0d", i),
            {62'd0, imem_if.req_valid, imem_if.req_addr, pc, halted},
            {62'd0, vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_addr, vecs[i].e_halted});
    end

    // misaligned redirect while stalled at pc 0x80000004
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h102, 1'b0, 1'b0, 1'b1);
    #1;
    check("mis_stall_valid", {127'd0, imem_if.req_valid}, 128'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
`ifdef PC_MISALIGN_CHECK_EN
    check("mis_ignored", {95'd0, misalign_err, pc}, {95'd0, 1'b1, 32'h8000_0004});
`else
    check("mis_unmodified", {96'd0, pc}, {96'd0, 32'h102});
`endif
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 1'b1);
    #1;
`ifdef PC_MISALIGN_CHECK_EN
    check("mis_pulse_end", {127'd0, misalign_err}, 128'd0);
`else
    check("mis_stall_hold", {96'd0, pc}, {96'd0, 32'h102});
`endif
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    #1;
`ifdef PC_MISALIGN_CHECK_EN
    check("aligned_accept", {94'd0, misalign_err, imem_if.req_valid, imem_if.req_addr}, {94'd0, 1'b0, 1'b1, 32'h104});
`else
    check("aligned_accept", {95'd0, imem_if.req_valid, imem_if.req_addr}, {95'd0, 1'b1, 32'h104});
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
